// File: rtl/fwd_pkg.sv
// Shared constants and the shadow-entry layout for the forwarding scoreboard.
// Select encoding: 0 reads the regfile, k forwards the result held in tracked stage k.
package fwd_pkg;

    localparam int FWD_REGFILE = 0;
    localparam int FWD_EXE     = 1;
    localparam int FWD_MEM     = 2;
    localparam int FWD_WB      = 3;

    localparam int FWD_AW = 5;
    localparam int FWD_LW = 2;

    // Default-configuration entry: valid, destination register, result-ready countdown.
    typedef struct packed {
        logic              v;
        logic [FWD_AW-1:0] addr;
        logic [FWD_LW-1:0] cnt;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_port_lookup.sv
// Priority matcher for one ID read port: youngest matching in-flight write decides.
// Purely combinational, zero latency; a matching entry that is not yet ready raises hazard.
module fwd_port_lookup
    import fwd_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int SW    = 2
) (
    input  logic                  active,
    input  logic [AW-1:0]         addr,
    input  logic [DEPTH-1:0]      ent_v,
    input  logic [DEPTH*AW-1:0]   ent_addr,
    input  logic [DEPTH-1:0]      ent_rdy,
    output logic [SW-1:0]         sel,
    output logic                  hazard
);

    // Scan oldest to youngest so the youngest match overrides any older one.
    always_comb begin
        sel    = SW'(FWD_REGFILE);
        hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (active && ent_v[k] && (ent_addr[k*AW +: AW] == addr)) begin
                sel    = ent_rdy[k] ? SW'(FWD_EXE + k) : SW'(FWD_REGFILE);
                hazard = ~ent_rdy[k];
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Shadow pipeline of in-flight register writes driving operand forward selects and load-use stall.
// Selects and stall are combinational from registered state; stall holds ID and bubbles EXE.
module fwd_scoreboard_unit
    import fwd_pkg::*;
#(
    parameter int AW    = 5,
    parameter int NRP   = 2,
    parameter int DEPTH = 3,
    parameter int LW    = 2,
    parameter int SW    = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                id_valid,
    input  logic [NRP-1:0]      id_rd_en,
    input  logic [NRP*AW-1:0]   id_rd_addr,
    input  logic                id_wr_en,
    input  logic [AW-1:0]       id_wr_addr,
    input  logic [LW-1:0]       id_wr_lat,
    input  logic                flush,
    output logic                stall,
    output logic [NRP*SW-1:0]   fwd_sel,
    output logic [15:0]         stall_cnt
);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] addr;
        logic [LW-1:0] cnt;
    } entry_t;

    localparam logic [LW-1:0] MAX_CNT = LW'(DEPTH - 1);

    entry_t                ent [DEPTH];
    logic [DEPTH-1:0]      ent_v;
    logic [DEPTH-1:0]      ent_rdy;
    logic [DEPTH*AW-1:0]   ent_addr;
    logic [NRP-1:0]        hazard;
    logic                  issue;
    logic [LW-1:0]         lat_clamp;

    always_comb begin
        ent_v    = '0;
        ent_rdy  = '0;
        ent_addr = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_v[k]              = ent[k].v;
            ent_rdy[k]            = (ent[k].cnt == '0);
            ent_addr[k*AW +: AW]  = ent[k].addr;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_port
        logic port_active;
        assign port_active = id_valid & id_rd_en[p] & (id_rd_addr[p*AW +: AW] != '0);

        fwd_port_lookup #(
            .AW    (AW),
            .DEPTH (DEPTH),
            .SW    (SW)
        ) u_lookup (
            .active   (port_active),
            .addr     (id_rd_addr[p*AW +: AW]),
            .ent_v    (ent_v),
            .ent_addr (ent_addr),
            .ent_rdy  (ent_rdy),
            .sel      (fwd_sel[p*SW +: SW]),
            .hazard   (hazard[p])
        );
    end

    // A squashed instruction neither stalls nor enters the shadow pipeline.
    assign stall     = (|hazard) & ~flush;
    assign issue     = id_valid & ~stall & ~flush & id_wr_en & (id_wr_addr != '0);
    assign lat_clamp = (id_wr_lat > MAX_CNT) ? MAX_CNT : id_wr_lat;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            ent[0] <= issue ? {1'b1, id_wr_addr, lat_clamp} : '0;
            for (int k = 1; k < DEPTH; k++) begin
                ent[k].v    <= ent[k-1].v;
                ent[k].addr <= ent[k-1].addr;
                ent[k].cnt  <= (ent[k-1].cnt == '0) ? '0 : ent[k-1].cnt - 1'b1;
            end
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: directed vector table, counter saturation, random vs age-based model.
module tb_fwd_scoreboard_unit;

    localparam int AW    = 5;
    localparam int NRP   = 2;
    localparam int DEPTH = 3;
    localparam int LW    = 2;
    localparam int SW    = 2;

    logic                clk = 1'b0;
    logic                nrst;
    logic                id_valid;
    logic [NRP-1:0]      id_rd_en;
    logic [NRP*AW-1:0]   id_rd_addr;
    logic                id_wr_en;
    logic [AW-1:0]       id_wr_addr;
    logic [LW-1:0]       id_wr_lat;
    logic                flush;
    logic                stall;
    logic [NRP*SW-1:0]   fwd_sel;
    logic [15:0]         stall_cnt;

    always #5 clk = ~clk;

    fwd_scoreboard_unit #(
        .AW (AW), .NRP (NRP), .DEPTH (DEPTH), .LW (LW), .SW (SW)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .id_valid   (id_valid),
        .id_rd_en   (id_rd_en),
        .id_rd_addr (id_rd_addr),
        .id_wr_en   (id_wr_en),
        .id_wr_addr (id_wr_addr),
        .id_wr_lat  (id_wr_lat),
        .flush      (flush),
        .stall      (stall),
        .fwd_sel    (fwd_sel),
        .stall_cnt  (stall_cnt)
    );

    // Reference model: each issued write remembered with the cycle it entered stage 1.
    typedef struct {
        int addr;
        int t;
        int lat;
    } rec_t;

    typedef struct {
        bit       rst_n;
        bit       vld;
        bit [1:0] rd;
        int       a0;
        int       a1;
        bit       wr;
        int       wa;
        int       lat;
        bit       fl;
        int       e_stall;
        int       e_sel0;
        int       e_sel1;
        int       e_cnt;
    } vec_t;

    rec_t recs[$];
    int   cyc;
    int   m_cnt;
    int   n_chk;
    int   n_pass;
    vec_t tbl[27];

    function automatic vec_t mk(bit rst_n, bit vld, bit [1:0] rd, int a0, int a1, bit wr, int wa,
                                int lat, bit fl, int es, int e0, int e1, int ec);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.rd = rd; v.a0 = a0; v.a1 = a1;
        v.wr = wr; v.wa = wa; v.lat = lat; v.fl = fl;
        v.e_stall = es; v.e_sel0 = e0; v.e_sel1 = e1; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic apply(input vec_t v);
        nrst       = v.rst_n;
        id_valid   = v.vld;
        id_rd_en   = v.rd;
        id_rd_addr = {AW'(v.a1), AW'(v.a0)};
        id_wr_en   = v.wr;
        id_wr_addr = AW'(v.wa);
        id_wr_lat  = LW'(v.lat);
        flush      = v.fl;
    endtask

    // Stage k holds a write issued k-1 cycles after it entered stage 1; ready once k-1 >= clamped latency.
    function automatic void model_port(input int p, output int sel, output bit haz);
        int a;
        int best;
        int blat;
        int age;
        int need;
        a    = int'(id_rd_addr[p*AW +: AW]);
        sel  = 0;
        haz  = 1'b0;
        best = DEPTH + 1;
        blat = 0;
        if (!(id_valid && id_rd_en[p] && a != 0)) return;
        foreach (recs[i]) begin
            age = cyc - recs[i].t + 1;
            if (age >= 1 && age <= DEPTH && recs[i].addr == a && age < best) begin
                best = age;
                blat = recs[i].lat;
            end
        end
        if (best <= DEPTH) begin
            need = (blat < DEPTH - 1) ? blat : DEPTH - 1;
            if (best - 1 >= need) sel = best;
            else haz = 1'b1;
        end
    endfunction

    task automatic run_cycle(input string name, input bit use_exp,
                             input int es, input int e0, input int e1, input int ec);
        int s0, s1;
        bit h0, h1, ms, mi;
        @(negedge clk);
        model_port(0, s0, h0);
        model_port(1, s1, h1);
        ms = (h0 | h1) & ~flush;
        if (use_exp) begin
            chk({name, ".stall"}, int'(stall), es);
            chk({name, ".sel0"}, int'(fwd_sel[SW-1:0]), e0);
            chk({name, ".sel1"}, int'(fwd_sel[2*SW-1:SW]), e1);
            chk({name, ".stall_cnt"}, int'(stall_cnt), ec);
        end else begin
            chk({name, ".stall"}, int'(stall), int'(ms));
            chk({name, ".sel0"}, int'(fwd_sel[SW-1:0]), s0);
            chk({name, ".sel1"}, int'(fwd_sel[2*SW-1:SW]), s1);
            chk({name, ".stall_cnt"}, int'(stall_cnt), m_cnt);
        end
        mi = id_valid && !ms && !flush && id_wr_en && (id_wr_addr != '0);
        @(posedge clk);
        cyc++;
        if (!nrst) begin
            recs.delete();
            m_cnt = 0;
        end else begin
            if (ms && m_cnt < 65535) m_cnt++;
            if (mi) recs.push_back('{addr: int'(id_wr_addr), t: cyc, lat: int'(id_wr_lat)});
            while (recs.size() > 0 && cyc - recs[0].t + 1 > DEPTH) void'(recs.pop_front());
        end
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        m_cnt  = 0;

        //           rst vld rd     a0 a1 wr wa lat fl   stall sel0 sel1 cnt
        tbl[0]  = mk(0, 0, 2'b00, 0, 0,  0, 0,  0, 0,   0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 2'b00, 0, 0,  1, 3,  0, 0,   0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 2'b01, 3, 0,  0, 0,  0, 0,   0, 1, 0, 0);
        tbl[3]  = mk(1, 1, 2'b01, 3, 0,  0, 0,  0, 0,   0, 2, 0, 0);
        tbl[4]  = mk(1, 1, 2'b11, 3, 3,  0, 0,  0, 0,   0, 3, 3, 0);
        tbl[5]  = mk(1, 1, 2'b01, 3, 0,  0, 0,  0, 0,   0, 0, 0, 0);
        tbl[6]  = mk(1, 1, 2'b00, 0, 0,  1, 5,  1, 0,   0, 0, 0, 0);
        tbl[7]  = mk(1, 1, 2'b10, 0, 5,  1, 6,  0, 0,   1, 0, 0, 0);
        tbl[8]  = mk(1, 1, 2'b10, 0, 5,  1, 6,  0, 0,   0, 0, 2, 1);
        tbl[9]  = mk(1, 1, 2'b00, 0, 0,  1, 4,  0, 0,   0, 0, 0, 1);
        tbl[10] = mk(1, 1, 2'b00, 0, 0,  1, 4,  0, 0,   0, 0, 0, 1);
        tbl[11] = mk(1, 1, 2'b01, 4, 0,  0, 0,  0, 0,   0, 1, 0, 1);
        tbl[12] = mk(1, 1, 2'b00, 0, 0,  1, 7,  0, 0,   0, 0, 0, 1);
        tbl[13] = mk(1, 1, 2'b00, 0, 0,  1, 7,  1, 0,   0, 0, 0, 1);
        tbl[14] = mk(1, 1, 2'b01, 7, 0,  0, 0,  0, 0,   1, 0, 0, 1);
        tbl[15] = mk(1, 1, 2'b01, 7, 0,  0, 0,  0, 0,   0, 2, 0, 2);
        tbl[16] = mk(1, 1, 2'b00, 0, 0,  1, 0,  0, 0,   0, 0, 0, 2);
        tbl[17] = mk(1, 1, 2'b11, 0, 0,  0, 0,  0, 0,   0, 0, 0, 2);
        tbl[18] = mk(1, 1, 2'b00, 0, 0,  1, 8,  1, 0,   0, 0, 0, 2);
        tbl[19] = mk(1, 1, 2'b00, 8, 8,  0, 0,  0, 0,   0, 0, 0, 2);
        tbl[20] = mk(1, 0, 2'b11, 8, 8,  0, 0,  0, 0,   0, 0, 0, 2);
        tbl[21] = mk(1, 1, 2'b00, 0, 0,  1, 9,  1, 0,   0, 0, 0, 2);
        tbl[22] = mk(1, 1, 2'b01, 9, 0,  1, 10, 0, 1,   0, 0, 0, 2);
        tbl[23] = mk(1, 1, 2'b11, 9, 10, 0, 0,  0, 0,   0, 2, 0, 2);
        tbl[24] = mk(1, 1, 2'b00, 0, 0,  1, 11, 1, 0,   0, 0, 0, 2);
        tbl[25] = mk(0, 1, 2'b10, 0, 11, 0, 0,  0, 0,   1, 0, 0, 2);
        tbl[26] = mk(1, 1, 2'b10, 0, 11, 0, 0,  0, 0,   0, 0, 0, 0);

        apply(tbl[0]);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i]);
            run_cycle($sformatf("vec%0d", i), 1'b1, tbl[i].e_stall, tbl[i].e_sel0,
                      tbl[i].e_sel1, tbl[i].e_cnt);
        end

        // Saturation: preload the counter near the top, then keep a self-dependent lat-2 load stalling.
        apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_cycle("sat_rst", 1'b0, 0, 0, 0, 0);
        force dut.stall_cnt = 16'hFFFD;
        #1;
        release dut.stall_cnt;
        m_cnt = 65533;
        apply(mk(1, 1, 2'b01, 12, 0, 1, 12, 2, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) run_cycle($sformatf("sat%0d", i), 1'b0, 0, 0, 0, 0);
        chk("sat_final", int'(stall_cnt), 65535);

        apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_cycle("rnd_rst", 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            nrst       = ($urandom_range(0, 63) != 0);
            id_valid   = ($urandom_range(0, 9) != 0);
            id_rd_en   = NRP'($urandom_range(0, 3));
            id_rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            id_wr_en   = ($urandom_range(0, 3) != 0);
            id_wr_addr = AW'($urandom_range(0, 7));
            id_wr_lat  = LW'($urandom_range(0, 3));
            flush      = ($urandom_range(0, 7) == 0);
            run_cycle($sformatf("rnd%0d", i), 1'b0, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
